proc_control: RTL and testbench
===============================

Name: proc_control

Overview:
Multi-cycle control unit for the 16-bit bus processor. It owns the time-step state machine, decodes the latched instruction word, and drives every register-enable, bus-source select, and ALU-operation line. It also asserts Done at the end of each instruction. It sits between the Run/DIN interface and the register file / A / G / ALU datapath, and replaces all ad-hoc control logic inside the processor top.

Parameters:
IR_W, 10, instruction width; opcode IR[9:6], X field IR[5:3], Y field IR[2:0]
NREG, 8, number of general registers; fixed to the 3-bit register fields

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Run  in  1  start request; sampled only in state T0
IR  in  IR_W  instruction register contents; IR register captures DIN when IRin=1
IRin  out  1  load enable for the instruction register
Rin  out  NREG  one-hot write enable, R0..R7 (bit i = Ri)
Rout  out  NREG  one-hot bus-source select, R0..R7
DINout  out  1  DIN drives the bus
Gout  out  1  G drives the bus
Ain  out  1  load enable for A
Gin  out  1  ALU result enable into G
AluOp  out  3  ALU function: 0 add, 1 sub, 2 or, 3 slt, 4 sll, 5 srl
Done  out  1  single-cycle pulse in the final step of an instruction
Busy  out  1  high in every state except T0

Behaviour:
- States: T0 (idle/fetch), T1, T2, T3. Encoding 2-bit, T0=0.
- Reset (synchronous, while Reset=1 at a rising edge):
  - next state T0.
  - all outputs 0 in the following cycle; AluOp=0.
  - Reset mid-instruction aborts with no register write and no Done.
- T0:
  - Run=0: remain in T0.
  - Run=1: IRin=1 (combinational in T0), next state T1.
- Opcode decode in T1..T3 uses the IR value latched at the end of T0.
- Opcode 6, mv Rx,Ry:
  - T1: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
- Opcode 7, mvi Rx,#D:
  - T1: DINout=1, Rin[X]=1, Done=1; next T0.
  - The immediate is the DIN word present during T1.
- Opcodes 0..5, ALU Rx,Ry:
  - T1: Rout[X]=1, Ain=1.
  - T2: Rout[Y]=1, Gin=1, AluOp=opcode[2:0].
  - T3: Gout=1, Rin[X]=1, Done=1; next T0.
  - Result is G = A op Ry, written back to Rx; latency is 4 cycles including T0.
- Opcodes 8..15 (illegal): T1: Done=1, no enables asserted; next T0.
- Bus exclusivity: at most one of {any Rout bit, DINout, Gout} is high in any cycle.
  - All are 0 in T0.
  - The bench asserts this every cycle.
- Run in T1..T3 is ignored; Run held high re-fetches in the T0 that follows Done.
- X==Y is legal:
  - mv R3,R3 rewrites the same value.
  - sub R2,R2 yields 0.
- AluOp holds 0 outside T2.
- Done is never high in two consecutive cycles.

Optional Feature:
PROC_CTRL_ILLEGAL_FLAG_EN
- Defined:
  - adds output Illegal (1 bit), a sticky flag set in T1 of any opcode >= 8.
  - cleared only by Reset.
  - Illegal instructions still complete in T1 with Done.
- Undefined: port absent; illegal opcodes are silent 2-cycle no-ops.

Decomposition:
- Shared package proc_pkg contains:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_OR=2, OP_SLT=3, OP_SLL=4, OP_SRL=5, OP_MV=6, OP_MVI=7.
  - state localparams T0..T3.
  - field bit positions for opcode, X, and Y.
- One sub-module: reg_sel_dec, a 3-to-8 one-hot decoder with enable (all-zero output when disabled). It is instantiated twice, for the X field and the Y field.

Test Plan:
- Reset held 2 cycles mid-T2 of an add → next cycle state T0, every output 0, no Rin pulse, no Done.
- Run=1, IR=mvi R5 (0x1E8), DIN=0x00A5 in T1 → T1: DINout=1, Rin=8'b0010_0000, Done=1; back in T0.
- IR=add R1,R2 (0x00A) → T1: Rout[1], Ain; T2: Rout[2], Gin, AluOp=0; T3: Gout, Rin[1], Done; R1=R1+R2.
- IR=sub R2,R2 (0x052) with R2=0x1234 → R2=0x0000 after T3; Done pulses exactly once.
- IR=0x3C0 (opcode 15) → Done in T1, no enables asserted; with PROC_CTRL_ILLEGAL_FLAG_EN, Illegal=1 and remains 1 until Reset.
- Run held high across 3 back-to-back mv instructions → each takes 2 cycles, Busy drops only in T0, bus-exclusivity assertion never fires.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, time-step states and instruction field positions
package proc_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_SLT = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_MV  = 4'd6;
    localparam logic [3:0] OP_MVI = 4'd7;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

endpackage

// File: rtl/reg_sel_dec.sv
// rtl/reg_sel_dec.sv - 3-to-8 one-hot register decoder with enable
module reg_sel_dec #(
    parameter int N = 8
) (
    input  logic                 en,
    input  logic [$clog2(N)-1:0] sel,
    output logic [N-1:0]         onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// rtl/proc_control.sv - T0..T3 control FSM for the 16-bit bus processor
// Optional sticky Illegal output with PROC_CTRL_ILLEGAL_FLAG_EN.
module proc_control
    import proc_pkg::*;
#(
    parameter int IR_W = 10,
    parameter int NREG = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            DINout,
    output logic            Gout,
    output logic            Ain,
    output logic            Gin,
    output logic [2:0]      AluOp,
    output logic            Done,
    output logic            Busy
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
    ,
    output logic            Illegal
`endif
);

    state_t state, state_next;

    logic [3:0]      opcode;
    logic [2:0]      x_sel;
    logic [2:0]      y_sel;
    logic [NREG-1:0] x_hot;
    logic [NREG-1:0] y_hot;

    assign opcode = IR[OP_MSB:OP_LSB];
    assign x_sel  = IR[X_MSB:X_LSB];
    assign y_sel  = IR[Y_MSB:Y_LSB];
    assign Busy   = (state != T0);

    // Decoders are gated off in T0 so no register is ever selected while idle.
    reg_sel_dec #(.N(NREG)) u_x_dec (
        .en     (Busy),
        .sel    (x_sel),
        .onehot (x_hot)
    );

    reg_sel_dec #(.N(NREG)) u_y_dec (
        .en     (Busy),
        .sel    (y_sel),
        .onehot (y_hot)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IRin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        DINout     = 1'b0;
        Gout       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AluOp      = 3'd0;
        Done       = 1'b0;
        case (state)
            T0: begin
                if (Run) begin
                    IRin       = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                if (opcode[3]) begin
                    Done       = 1'b1;
                    state_next = T0;
                end else if (opcode == OP_MV) begin
                    Rout       = y_hot;
                    Rin        = x_hot;
                    Done       = 1'b1;
                    state_next = T0;
                end else if (opcode == OP_MVI) begin
                    DINout     = 1'b1;
                    Rin        = x_hot;
                    Done       = 1'b1;
                    state_next = T0;
                end else begin
                    Rout       = x_hot;
                    Ain        = 1'b1;
                    state_next = T2;
                end
            end
            T2: begin
                Rout       = y_hot;
                Gin        = 1'b1;
                AluOp      = opcode[2:0];
                state_next = T3;
            end
            T3: begin
                Gout       = 1'b1;
                Rin        = x_hot;
                Done       = 1'b1;
                state_next = T0;
            end
            default: state_next = T0;
        endcase
    end

`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Illegal <= 1'b0;
        end else if (state == T1 && opcode[3]) begin
            Illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - directed self-checking bench for proc_control with a small datapath model
module tb_proc_control;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [9:0]  IR;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        DINout;
    logic        Gout;
    logic        Ain;
    logic        Gin;
    logic [2:0]  AluOp;
    logic        Done;
    logic        Busy;
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
    logic        Illegal;
`endif

    logic [15:0] din;
    logic [15:0] regs [8];
    logic [15:0] a_q;
    logic [15:0] g_q;
    logic [9:0]  ir_q;
    logic [15:0] bus;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    logic done_prev = 1'b0;
    logic mon_en = 1'b0;
    int d0;

    proc_control #(.IR_W(10), .NREG(8)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Run     (Run),
        .IR      (IR),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .DINout  (DINout),
        .Gout    (Gout),
        .Ain     (Ain),
        .Gin     (Gin),
        .AluOp   (AluOp),
        .Done    (Done),
        .Busy    (Busy)
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
        ,
        .Illegal (Illegal)
`endif
    );

    always #5 Clock = ~Clock;

    assign IR = ir_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
        case (op)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x | y;
            3'd3:    return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
            3'd4:    return x << y[3:0];
            3'd5:    return x >> y[3:0];
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        bus = 16'd0;
        if (DINout) begin
            bus = din;
        end else if (Gout) begin
            bus = g_q;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (Rout[i]) bus = regs[i];
            end
        end
    end

    initial begin
        ir_q = 10'd0;
        a_q  = 16'd0;
        g_q  = 16'd0;
        for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    end

    always @(posedge Clock) begin
        if (IRin) ir_q <= din[9:0];
        for (int i = 0; i < 8; i++) begin
            if (Rin[i]) regs[i] <= bus;
        end
        if (Ain) a_q <= bus;
        if (Gin) g_q <= alu(a_q, bus, AluOp);
    end

    always @(negedge Clock) begin
        if (mon_en && !Reset) begin
            check("bus_excl", 32'(($countones(Rout) + DINout + Gout) <= 1), 32'd1);
            check("done_consec", 32'(Done && done_prev), 32'd0);
        end
        done_prev <= Done;
        if (Done) done_total <= done_total + 1;
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".IRin"},   IRin,   0);
        check({tag, ".Rin"},    Rin,    0);
        check({tag, ".Rout"},   Rout,   0);
        check({tag, ".DINout"}, DINout, 0);
        check({tag, ".Gout"},   Gout,   0);
        check({tag, ".Ain"},    Ain,    0);
        check({tag, ".Gin"},    Gin,    0);
        check({tag, ".AluOp"},  AluOp,  0);
        check({tag, ".Done"},   Done,   0);
        check({tag, ".Busy"},   Busy,   0);
    endtask

    task automatic fetch(input logic [15:0] instr);
        Run = 1'b1;
        din = instr;
        #1;
        check("fetch.IRin", IRin, 1);
        check("fetch.Busy", Busy, 0);
        tick();
        Run = 1'b0;
        #1;
    endtask

    task automatic load_imm(input int x, input logic [15:0] val);
        fetch(16'h01C0 | 16'(x << 3));
        din = val;
        tick();
    endtask

    initial begin
        logic [15:0] mv_ir  [3];
        logic [7:0]  mv_rin [3];
        logic [7:0]  mv_rout[3];
        mv_ir   = '{16'h0199, 16'h01A3, 16'h019B};
        mv_rin  = '{8'h08, 8'h10, 8'h08};
        mv_rout = '{8'h02, 8'h08, 8'h08};

        Reset = 1'b1;
        Run   = 1'b0;
        din   = 16'd0;
        tick();
        tick();
        check_idle("reset");
        Reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        check_idle("post_reset");

        // mvi R5,#0x00A5
        fetch(16'h01E8);
        din = 16'h00A5;
        #1;
        check("mvi.DINout", DINout, 1);
        check("mvi.Rin",    Rin,    8'h20);
        check("mvi.Rout",   Rout,   0);
        check("mvi.Done",   Done,   1);
        check("mvi.Busy",   Busy,   1);
        tick();
        check("mvi.R5",     regs[5], 16'h00A5);
        check("mvi.T0Busy", Busy,    0);
        check("mvi.T0Done", Done,    0);

        // add R1,R2 with R1=0x11, R2=0x22
        load_imm(1, 16'h0011);
        load_imm(2, 16'h0022);
        fetch(16'h000A);
        check("add.T1.Rout",  Rout,  8'h02);
        check("add.T1.Ain",   Ain,   1);
        check("add.T1.Rin",   Rin,   0);
        check("add.T1.Done",  Done,  0);
        check("add.T1.AluOp", AluOp, 0);
        check("add.T1.Busy",  Busy,  1);
        tick();
        check("add.T2.Rout",  Rout,  8'h04);
        check("add.T2.Gin",   Gin,   1);
        check("add.T2.Ain",   Ain,   0);
        check("add.T2.AluOp", AluOp, 0);
        check("add.T2.Done",  Done,  0);
        tick();
        check("add.T3.Gout",  Gout,  1);
        check("add.T3.Rin",   Rin,   8'h02);
        check("add.T3.Rout",  Rout,  0);
        check("add.T3.Done",  Done,  1);
        check("add.T3.Gin",   Gin,   0);
        tick();
        check("add.R1",       regs[1], 16'h0033);
        check("add.T0Busy",   Busy,    0);

        // sub R2,R2 with R2=0x1234
        load_imm(2, 16'h1234);
        d0 = done_total;
        fetch(16'h0052);
        tick();
        check("sub.T2.AluOp", AluOp, 3'd1);
        check("sub.T2.Rout",  Rout,  8'h04);
        tick();
        check("sub.T3.AluOp", AluOp, 0);
        tick();
        check("sub.R2",       regs[2], 16'h0000);
        check("sub.done_cnt", done_total - d0, 1);

        // or R1,R5: 0x33 | 0xA5
        fetch(16'h008D);
        tick();
        check("or.T2.AluOp", AluOp, 3'd2);
        tick();
        tick();
        check("or.R1", regs[1], 16'h00B7);

        // illegal opcode 15
        fetch(16'h03C0);
        check("ill.Done",   Done,   1);
        check("ill.Rin",    Rin,    0);
        check("ill.Rout",   Rout,   0);
        check("ill.Ain",    Ain,    0);
        check("ill.Gin",    Gin,    0);
        check("ill.DINout", DINout, 0);
        check("ill.Gout",   Gout,   0);
        check("ill.Busy",   Busy,   1);
        tick();
        check("ill.T0Busy", Busy,   0);
        check("ill.T0Done", Done,   0);
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
        check("ill.flag",   Illegal, 1);
`endif

        // three back-to-back mv with Run held high
        Run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = mv_ir[k];
            #1;
            check("mv.T0.IRin", IRin, 1);
            check("mv.T0.Busy", Busy, 0);
            tick();
            check("mv.T1.Busy", Busy, 1);
            check("mv.T1.Done", Done, 1);
            check("mv.T1.IRin", IRin, 0);
            check("mv.T1.Rin",  Rin,  mv_rin[k]);
            check("mv.T1.Rout", Rout, mv_rout[k]);
            tick();
        end
        Run = 1'b0;
        #1;
        check("mv.R3", regs[3], 16'h00B7);
        check("mv.R4", regs[4], 16'h00B7);
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
        check("ill.sticky", Illegal, 1);
`endif

        // reset held 2 cycles in T2 of add R1,R2
        fetch(16'h000A);
        tick();
        check("rst.T2.Gin", Gin, 1);
        d0 = done_total;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        check("rst.R1",   regs[1], 16'h00B7);
        check("rst.done", done_total - d0, 0);
`ifdef PROC_CTRL_ILLEGAL_FLAG_EN
        check("rst.flag", Illegal, 0);
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
